ofdm_frame_sync: RTL and testbench

Parametrised OFDM frame synchroniser between the ADC sample-rate stage and the FFT. It detects a burst onset by comparing a long and a short block-averaged magnitude metric, drops each cyclic prefix, and forwards NUM_SYMBOLS symbols as Avalon-ST packets with optional sample negation. It drives `pre_sampling` back to the sampler and enforces a guard interval before re-arming.

---
 rtl/ofdm_sync_pkg.sv | 33 +++
 rtl/ofdm_frame_sync_avg.sv | 56 +++++
 rtl/ofdm_frame_sync.sv | 179 +++++++++++++++++
 tb/tb_ofdm_frame_sync.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_sync_pkg.sv
// Shared types and arithmetic helpers for the OFDM frame synchroniser.
package ofdm_sync_pkg;

    typedef enum logic [1:0] {
        ST_DETECT  = 2'd0,
        ST_SKIP_CP = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_GUARD   = 2'd3
    } sync_state_e;

    // |I| + |Q| on sign-extended components; callers keep the low DATA_W+1 bits.
    function automatic logic [32:0] metric(input logic signed [31:0] i_v,
                                           input logic signed [31:0] q_v);
        logic [31:0] ai;
        logic [31:0] aq;
        ai = i_v[31] ? 32'(-i_v) : 32'(i_v);
        aq = q_v[31] ? 32'(-q_v) : 32'(q_v);
        return {1'b0, ai} + {1'b0, aq};
    endfunction

    // Two's-complement negation of a w-bit value; the most negative code clamps to max positive.
    function automatic logic signed [31:0] neg_sat(input logic signed [31:0] x,
                                                   input int w);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (x < -lim) begin
            return lim;
        end else begin
            return -x;
        end
    endfunction

endpackage

// File: rtl/ofdm_frame_sync_avg.sv
// Block averager: sums 2^LOG2 metric values, then publishes sum >> LOG2 and restarts.
module ofdm_block_avg #(
    parameter int W    = 17,
    parameter int LOG2 = 5
) (
    input  logic         clock_clk,
    input  logic         reset_reset_n,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [W-1:0] m,
    output logic [W-1:0] avg,
    output logic         avg_strobe,
    output logic         seen_one
);

    localparam int AW = W + LOG2;

    logic [AW-1:0]   acc_r;
    logic [LOG2-1:0] cnt_r;
    logic [W-1:0]    avg_r;
    logic            seen_r;
    logic [AW-1:0]   sum_s;
    logic            last_s;

    assign sum_s      = acc_r + {{LOG2{1'b0}}, m};
    assign last_s     = (cnt_r == {LOG2{1'b1}});
    assign avg_strobe = in_valid && last_s;
    // During the completing sample the fresh average is presented so the caller can act on it at once.
    assign avg        = avg_strobe ? sum_s[AW-1:LOG2] : avg_r;
    assign seen_one   = seen_r;

    // Window accumulator, sample counter and held average.
    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            acc_r  <= {AW{1'b0}};
            cnt_r  <= {LOG2{1'b0}};
            avg_r  <= {W{1'b0}};
            seen_r <= 1'b0;
        end else if (clr) begin
            acc_r  <= {AW{1'b0}};
            cnt_r  <= {LOG2{1'b0}};
            avg_r  <= {W{1'b0}};
            seen_r <= 1'b0;
        end else if (in_valid) begin
            cnt_r <= cnt_r + {{(LOG2-1){1'b0}}, 1'b1};
            if (last_s) begin
                acc_r  <= {AW{1'b0}};
                avg_r  <= sum_s[AW-1:LOG2];
                seen_r <= 1'b1;
            end else begin
                acc_r <= sum_s;
            end
        end
    end

endmodule

// File: rtl/ofdm_frame_sync.sv
// OFDM burst detector and cyclic-prefix stripper feeding the FFT as Avalon-ST packets.
module ofdm_frame_sync
    import ofdm_sync_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SYMBOL_LEN  = 64,
    parameter int CP_LEN      = 16,
    parameter int NUM_SYMBOLS = 1,
    parameter int LONG_LOG2   = 5,
    parameter int SHORT_LOG2  = 1,
    parameter int GUARD_LEN   = 64,
    parameter int INVERT      = 1
) (
    input  logic                               clock_clk,
    input  logic                               reset_reset_n,
    input  logic [DATA_W:0]                    threshold,
    input  logic [2*DATA_W-1:0]                asi_in0_data,
    input  logic                               asi_in0_valid,
    output logic [2*DATA_W-1:0]                aso_out0_data,
    output logic                               aso_out0_valid,
    output logic                               aso_out0_startofpacket,
    output logic                               aso_out0_endofpacket,
    output logic [$clog2(NUM_SYMBOLS+1)-1:0]   symbol_index,
    output logic                               pre_sampling,
    output logic [15:0]                        frame_count
);

    localparam int MW      = DATA_W + 1;
    localparam int SYM_W   = $clog2(NUM_SYMBOLS + 1);
    localparam int MAX_AB  = (SYMBOL_LEN > CP_LEN) ? SYMBOL_LEN : CP_LEN;
    localparam int MAX_LEN = (MAX_AB > GUARD_LEN) ? MAX_AB : GUARD_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    sync_state_e        state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [SYM_W-1:0]   sym_r;
    logic [MW-1:0]      avg_long_r;

    logic signed [DATA_W-1:0] i_s;
    logic signed [DATA_W-1:0] q_s;
    logic [DATA_W-1:0]        neg_i_s;
    logic [DATA_W-1:0]        neg_q_s;
    logic [2*DATA_W-1:0]      fwd_s;
    logic [MW-1:0]            m_s;
    logic                     det_valid_s;
    logic                     clr_s;
    logic [MW-1:0]            long_avg_s;
    logic                     long_strobe_s;
    logic                     long_ok_s;
    logic [MW-1:0]            short_avg_s;
    logic                     short_strobe_s;
    logic                     short_seen_s;
    logic [MW-1:0]            diff_s;
    logic                     trig_s;
    sync_state_e              after_sym_s;

    assign i_s         = asi_in0_data[2*DATA_W-1:DATA_W];
    assign q_s         = asi_in0_data[DATA_W-1:0];
    assign m_s         = MW'(metric(32'(i_s), 32'(q_s)));
    assign neg_i_s     = DATA_W'(neg_sat(32'(i_s), DATA_W));
    assign neg_q_s     = DATA_W'(neg_sat(32'(q_s), DATA_W));
    assign fwd_s       = (INVERT != 0) ? {neg_i_s, neg_q_s} : asi_in0_data;
    assign det_valid_s = asi_in0_valid && (state_r == ST_DETECT);
    assign clr_s       = (state_r == ST_GUARD);
    assign after_sym_s = (CP_LEN == 0) ? ST_PAYLOAD : ST_SKIP_CP;

    ofdm_block_avg #(.W(MW), .LOG2(LONG_LOG2)) u_long (
        .clock_clk     (clock_clk),
        .reset_reset_n (reset_reset_n),
        .clr           (clr_s),
        .in_valid      (det_valid_s),
        .m             (m_s),
        .avg           (long_avg_s),
        .avg_strobe    (long_strobe_s),
        .seen_one      (long_ok_s)
    );

    ofdm_block_avg #(.W(MW), .LOG2(SHORT_LOG2)) u_short (
        .clock_clk     (clock_clk),
        .reset_reset_n (reset_reset_n),
        .clr           (clr_s),
        .in_valid      (det_valid_s),
        .m             (m_s),
        .avg           (short_avg_s),
        .avg_strobe    (short_strobe_s),
        .seen_one      (short_seen_s)
    );

    // The long reference is the last published long average, never the one completing this sample.
    assign diff_s = (avg_long_r >= short_avg_s) ? (avg_long_r - short_avg_s)
                                                : (short_avg_s - avg_long_r);
    assign trig_s = short_strobe_s && long_ok_s && short_seen_s && (diff_s > threshold);

    // Registered copy of the long average used as the detection reference.
    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            avg_long_r <= {MW{1'b0}};
        end else if (clr_s) begin
            avg_long_r <= {MW{1'b0}};
        end else if (long_strobe_s) begin
            avg_long_r <= long_avg_s;
        end
    end

    // Frame state machine with registered stream outputs.
    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            state_r                <= ST_DETECT;
            cnt_r                  <= {CNT_W{1'b0}};
            sym_r                  <= {SYM_W{1'b0}};
            aso_out0_data          <= {(2*DATA_W){1'b0}};
            aso_out0_valid         <= 1'b0;
            aso_out0_startofpacket <= 1'b0;
            aso_out0_endofpacket   <= 1'b0;
            symbol_index           <= {SYM_W{1'b0}};
            pre_sampling           <= 1'b1;
            frame_count            <= 16'd0;
        end else begin
            aso_out0_valid         <= 1'b0;
            aso_out0_startofpacket <= 1'b0;
            aso_out0_endofpacket   <= 1'b0;
            case (state_r)
                ST_DETECT: begin
                    if (trig_s) begin
                        pre_sampling <= 1'b0;
                        frame_count  <= frame_count + 16'd1;
                        sym_r        <= {SYM_W{1'b0}};
                        symbol_index <= {SYM_W{1'b0}};
                        cnt_r        <= {CNT_W{1'b0}};
                        state_r      <= after_sym_s;
                    end
                end
                ST_SKIP_CP: begin
                    if (asi_in0_valid) begin
                        if (cnt_r == CNT_W'(CP_LEN - 1)) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= ST_PAYLOAD;
                        end else begin
                            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (asi_in0_valid) begin
                        aso_out0_data          <= fwd_s;
                        aso_out0_valid         <= 1'b1;
                        aso_out0_startofpacket <= (cnt_r == {CNT_W{1'b0}});
                        aso_out0_endofpacket   <= (cnt_r == CNT_W'(SYMBOL_LEN - 1));
                        symbol_index           <= sym_r;
                        if (cnt_r == CNT_W'(SYMBOL_LEN - 1)) begin
                            cnt_r <= {CNT_W{1'b0}};
                            if (sym_r < SYM_W'(NUM_SYMBOLS - 1)) begin
                                sym_r   <= sym_r + {{(SYM_W-1){1'b0}}, 1'b1};
                                state_r <= after_sym_s;
                            end else begin
                                state_r <= ST_GUARD;
                            end
                        end else begin
                            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_GUARD: begin
                    if (cnt_r == CNT_W'(GUARD_LEN - 1)) begin
                        cnt_r        <= {CNT_W{1'b0}};
                        pre_sampling <= 1'b1;
                        state_r      <= ST_DETECT;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_DETECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_frame_sync.sv
// Scoreboard bench for ofdm_frame_sync: one default instance and one with NUM_SYMBOLS=2.
module tb_ofdm_frame_sync;

    logic        clock_clk = 1'b0;
    logic        reset_reset_n;
    logic [16:0] threshold;
    logic [31:0] asi_in0_data;
    logic        asi_in0_valid;
    logic        sel2;
    logic        valid1;
    logic        valid2;

    logic [31:0] d1, d2;
    logic        v1, v2, sop1, sop2, eop1, eop2, pre1, pre2;
    logic [0:0]  idx1;
    logic [1:0]  idx2;
    logic [15:0] fc1, fc2;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  idx;
        logic [15:0] fc;
        longint      cyc;
    } exp_t;

    exp_t   q1[$];
    exp_t   q2[$];
    int     total = 0;
    int     bad   = 0;
    longint edge_n = 0;

    always #5 clock_clk = ~clock_clk;

    assign valid1 = asi_in0_valid & ~sel2;
    assign valid2 = asi_in0_valid & sel2;

    ofdm_frame_sync u_dut1 (
        .clock_clk              (clock_clk),
        .reset_reset_n          (reset_reset_n),
        .threshold              (threshold),
        .asi_in0_data           (asi_in0_data),
        .asi_in0_valid          (valid1),
        .aso_out0_data          (d1),
        .aso_out0_valid         (v1),
        .aso_out0_startofpacket (sop1),
        .aso_out0_endofpacket   (eop1),
        .symbol_index           (idx1),
        .pre_sampling           (pre1),
        .frame_count            (fc1)
    );

    ofdm_frame_sync #(.NUM_SYMBOLS(2)) u_dut2 (
        .clock_clk              (clock_clk),
        .reset_reset_n          (reset_reset_n),
        .threshold              (threshold),
        .asi_in0_data           (asi_in0_data),
        .asi_in0_valid          (valid2),
        .aso_out0_data          (d2),
        .aso_out0_valid         (v2),
        .aso_out0_startofpacket (sop2),
        .aso_out0_endofpacket   (eop2),
        .symbol_index           (idx2),
        .pre_sampling           (pre2),
        .frame_count            (fc2)
    );

    always @(posedge clock_clk) edge_n <= edge_n + 64'd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic s, input logic e,
                       input logic [31:0] d, input logic [1:0] ix, input logic [15:0] fc);
        exp_t x;
        int   n;
        if (!v && (s || e)) chk($sformatf("dut%0d_sop_eop_idle", id), {62'd0, s, e}, 64'd0);
        if (v) begin
            n = (id == 1) ? q1.size() : q2.size();
            if (n == 0) begin
                chk($sformatf("dut%0d_unexpected_valid", id), {63'd0, v}, 64'd0);
            end else begin
                if (id == 1) x = q1.pop_front();
                else x = q2.pop_front();
                chk($sformatf("dut%0d_data", id), {32'd0, d}, {32'd0, x.data});
                chk($sformatf("dut%0d_sop", id), {63'd0, s}, {63'd0, x.sop});
                chk($sformatf("dut%0d_eop", id), {63'd0, e}, {63'd0, x.eop});
                chk($sformatf("dut%0d_idx", id), {62'd0, ix}, {62'd0, x.idx});
                chk($sformatf("dut%0d_fc", id), {48'd0, fc}, {48'd0, x.fc});
                chk($sformatf("dut%0d_latency_cycle", id), 64'(edge_n), 64'(x.cyc));
            end
        end
    endtask

    always @(negedge clock_clk) begin
        mon(1, v1, sop1, eop1, d1, {1'b0, idx1}, fc1);
        mon(2, v2, sop2, eop2, d2, idx2, fc2);
    end

    task automatic send(input logic v, input logic signed [15:0] i_v);
        asi_in0_valid = v;
        asi_in0_data  = {i_v, 16'h0000};
        @(posedge clock_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        repeat (3) send(1'b0, 16'sd0);
        reset_reset_n = 1'b1;
    endtask

    // 64 samples of 10, trigger pair of 1000, then CP + payload carrying pay_i.
    task automatic run_burst(input int which, input bit gap, input logic signed [15:0] pay_i,
                             input int nsym, input int abort_at);
        logic signed [16:0] t;
        exp_t               x;
        sel2 = (which == 2);
        t = -{pay_i[15], pay_i};
        if (t > 17'sd32767) t = 17'sd32767;
        for (int k = 1; k <= 64; k++) send(1'b1, 16'sd10);
        send(1'b1, 16'sd1000);
        chk("pre_before_trigger", {63'd0, (which == 2) ? pre2 : pre1}, 64'd1);
        send(1'b1, 16'sd1000);
        chk("pre_after_trigger", {63'd0, (which == 2) ? pre2 : pre1}, 64'd0);
        chk("fc_after_trigger", {48'd0, (which == 2) ? fc2 : fc1}, 64'd1);
        for (int s = 0; s < nsym; s++) begin
            for (int k = 0; k < 16; k++) send(1'b1, pay_i);
            for (int j = 1; j <= 64; j++) begin
                if (j == abort_at) begin
                    reset_reset_n = 1'b0;
                    send(1'b0, 16'sd0);
                    chk("abort_valid", {63'd0, v1}, 64'd0);
                    chk("abort_eop", {63'd0, eop1}, 64'd0);
                    chk("abort_data", {32'd0, d1}, 64'd0);
                    chk("abort_pre", {63'd0, pre1}, 64'd1);
                    chk("abort_fc", {48'd0, fc1}, 64'd0);
                    chk("abort_sb_left", 64'(q1.size()), 64'd0);
                    send(1'b0, 16'sd0);
                    send(1'b0, 16'sd0);
                    reset_reset_n = 1'b1;
                    sel2 = 1'b0;
                    return;
                end
                if (gap && j > 1) send(1'b0, 16'sd0);
                x.data = {t[15:0], 16'h0000};
                x.sop  = (j == 1);
                x.eop  = (j == 64);
                x.idx  = 2'(s);
                x.fc   = 16'd1;
                x.cyc  = edge_n + 64'd1;
                if (which == 2) q2.push_back(x);
                else q1.push_back(x);
                send(1'b1, pay_i);
            end
        end
        repeat (63) send(1'b1, pay_i);
        chk("guard_pre_low", {63'd0, (which == 2) ? pre2 : pre1}, 64'd0);
        send(1'b1, pay_i);
        chk("guard_pre_high", {63'd0, (which == 2) ? pre2 : pre1}, 64'd1);
        sel2 = 1'b0;
    endtask

    initial begin
        sel2          = 1'b0;
        asi_in0_valid = 1'b0;
        asi_in0_data  = 32'd0;
        threshold     = 17'd100;
        reset_reset_n = 1'b1;
        do_reset();
        chk("rst_valid", {63'd0, v1}, 64'd0);
        chk("rst_sop", {63'd0, sop1}, 64'd0);
        chk("rst_eop", {63'd0, eop1}, 64'd0);
        chk("rst_data", {32'd0, d1}, 64'd0);
        chk("rst_idx", {63'd0, idx1}, 64'd0);
        chk("rst_pre", {63'd0, pre1}, 64'd1);
        chk("rst_fc", {48'd0, fc1}, 64'd0);
        chk("rst_pre2", {63'd0, pre2}, 64'd1);
        chk("rst_fc2", {48'd0, fc2}, 64'd0);

        for (int k = 0; k < 500; k++) send(1'b1, 16'sd100);
        chk("const_pre", {63'd0, pre1}, 64'd1);
        chk("const_fc", {48'd0, fc1}, 64'd0);

        do_reset();
        run_burst(1, 1'b0, 16'sd1000, 1, 0);
        do_reset();
        run_burst(2, 1'b0, 16'sd1000, 2, 0);
        do_reset();
        run_burst(1, 1'b1, 16'sd1000, 1, 0);
        do_reset();
        run_burst(1, 1'b0, -16'sd32768, 1, 0);
        do_reset();
        run_burst(1, 1'b0, -16'sd32768, 1, 30);
        run_burst(1, 1'b0, -16'sd32768, 1, 0);

        repeat (3) send(1'b0, 16'sd0);
        chk("sb1_drained", 64'(q1.size()), 64'd0);
        chk("sb2_drained", 64'(q2.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
